pixel_coordinate_generator: RTL

Upstream driver for the triangle sampler's triangle and pixel-coordinate inputs. It accepts one triangle and forwards it to the sampler. It then streams every pixel coordinate of the viewport in row-major order on a valid/ready handshake. It counts completed sampler results and pulses done once all results for the triangle have returned. It sits between the triangle setup stage and the sampler.

---
 rtl/types_pkg.sv | 37 +++
 rtl/pixel_coordinate_generator.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/types_pkg.sv
// Shared types for the triangle rasterisation pipeline: triangle and pixel
// coordinate payloads plus the state encodings of the sampler and its driver.
package types_pkg;

   localparam int COORD_X_W = 8;
   localparam int COORD_Y_W = 7;

   typedef struct packed {
      logic [COORD_X_W-1:0] x;
      logic [COORD_Y_W-1:0] y;
   } vertex_t;

   typedef struct packed {
      vertex_t v0;
      vertex_t v1;
      vertex_t v2;
   } triangle_t;

   typedef struct packed {
      logic [COORD_X_W-1:0] x;
      logic [COORD_Y_W-1:0] y;
   } pixel_coordinate_t;

   typedef enum logic [1:0] {
      SAMPLER_IDLE = 2'd0,
      SAMPLER_EVAL = 2'd1,
      SAMPLER_EMIT = 2'd2
   } sampler_state;

   typedef enum logic [1:0] {
      IDLE          = 2'd0,
      SEND_TRIANGLE = 2'd1,
      SCAN          = 2'd2,
      DRAIN         = 2'd3
   } pixel_coordinate_generator_state;

endpackage

// File: rtl/pixel_coordinate_generator.sv
// Forwards one triangle to the sampler, streams every viewport coordinate in
// row-major order, and pulses done once every sampler result has come back.
module pixel_coordinate_generator
   import types_pkg::*;
#(
   parameter int VIEWPORT_WIDTH  = 160,
   parameter int VIEWPORT_HEIGHT = 120
) (
   input  logic              clk,
   input  logic              rst,
   output logic              triangle_s_ready,
   input  logic              triangle_s_valid,
   input  triangle_t         triangle_s_data,
   input  logic              triangle_m_ready,
   output logic              triangle_m_valid,
   output triangle_t         triangle_m_data,
   input  logic              pixel_coordinate_m_ready,
   output logic              pixel_coordinate_m_valid,
   output pixel_coordinate_t pixel_coordinate_m_data,
   input  logic              result_fire,
   output logic              busy,
   output logic              done
);

   localparam int TOTAL_PIXELS = VIEWPORT_WIDTH * VIEWPORT_HEIGHT;
   localparam int COUNT_W      = $clog2(TOTAL_PIXELS + 1);
   localparam int X_W          = $clog2(VIEWPORT_WIDTH);
   localparam int Y_W          = $clog2(VIEWPORT_HEIGHT);

   localparam logic [X_W-1:0]     X_LAST    = X_W'(VIEWPORT_WIDTH - 1);
   localparam logic [Y_W-1:0]     Y_LAST    = Y_W'(VIEWPORT_HEIGHT - 1);
   localparam logic [COUNT_W-1:0] COUNT_END = COUNT_W'(TOTAL_PIXELS);

   pixel_coordinate_generator_state state_q, state_d;
   logic [X_W-1:0]     x_q, x_d;
   logic [Y_W-1:0]     y_q, y_d;
   logic [COUNT_W-1:0] returned_q, returned_d;
   triangle_t          triangle_q, triangle_d;
   logic               done_q, done_d;

   // State, raster position, result count, latched triangle and done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         x_q        <= '0;
         y_q        <= '0;
         returned_q <= '0;
         triangle_q <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         y_q        <= y_d;
         returned_q <= returned_d;
         triangle_q <= triangle_d;
         done_q     <= done_d;
      end
   end

   // Next-state, raster advance and saturating result counter.
   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      triangle_d = triangle_q;
      done_d     = 1'b0;

      // Results arriving while idle belong to no triangle and are dropped.
      if ((state_q != IDLE) && result_fire && (returned_q != COUNT_END)) begin
         returned_d = returned_q + COUNT_W'(1);
      end else begin
         returned_d = returned_q;
      end

      case (state_q)
         IDLE: begin
            if (triangle_s_valid) begin
               triangle_d = triangle_s_data;
               x_d        = '0;
               y_d        = '0;
               returned_d = '0;
               state_d    = SEND_TRIANGLE;
            end else begin
               state_d    = IDLE;
            end
         end
         SEND_TRIANGLE: begin
            if (triangle_m_ready) begin
               state_d = SCAN;
            end else begin
               state_d = SEND_TRIANGLE;
            end
         end
         SCAN: begin
            if (pixel_coordinate_m_ready) begin
               if (x_q == X_LAST) begin
                  // Last pixel parks the counters instead of wrapping them.
                  if (y_q == Y_LAST) begin
                     state_d = DRAIN;
                  end else begin
                     x_d = '0;
                     y_d = y_q + Y_W'(1);
                  end
               end else begin
                  x_d = x_q + X_W'(1);
               end
            end else begin
               state_d = SCAN;
            end
         end
         DRAIN: begin
            if (returned_q == COUNT_END) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = DRAIN;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Handshake signals decode straight from the state register.
   always_comb begin
      triangle_s_ready         = 1'b0;
      triangle_m_valid         = 1'b0;
      pixel_coordinate_m_valid = 1'b0;
      busy                     = 1'b1;
      case (state_q)
         IDLE: begin
            triangle_s_ready = 1'b1;
            busy             = 1'b0;
         end
         SEND_TRIANGLE: begin
            triangle_m_valid = 1'b1;
         end
         SCAN: begin
            pixel_coordinate_m_valid = 1'b1;
         end
         DRAIN: begin
            busy = 1'b1;
         end
         default: begin
            busy = 1'b1;
         end
      endcase
   end

   assign triangle_m_data           = triangle_q;
   assign pixel_coordinate_m_data.x = COORD_X_W'(x_q);
   assign pixel_coordinate_m_data.y = COORD_Y_W'(y_q);
   assign done                      = done_q;

endmodule
